// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and its datapath:
// opcode in, enables / mux selects / debug state out.
interface multicycle_control_if;
  logic [5:0] op;
  logic       PCWrite;
  logic       Branch;
  logic       BranchNe;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemtoReg;
  logic       RegDst;
  logic       RegWrite;
  logic       AluSrcA;
  logic [1:0] AluSrcB;
  logic [1:0] Alu_op;
  logic [1:0] PCSource;
  logic [3:0] state;
  logic       illegal_op;

  // No valid/ready here: op is a level the controller samples only while in
  // DECODE; every output is a level valid for the whole cycle it is shown.
  modport master (
    input  op,
    output PCWrite, Branch, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, AluSrcA, AluSrcB, Alu_op, PCSource,
           state, illegal_op
  );

  modport slave (
    output op,
    input  PCWrite, Branch, BranchNe, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, AluSrcA, AluSrcB, Alu_op, PCSource,
           state, illegal_op
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore controller for a multicycle MIPS-style datapath with memory wait states,
// optional bne decode and an illegal-opcode pulse. Outputs are registered.
module multicycle_control #(
  parameter int MEM_WAIT   = 0,
  parameter int ENABLE_BNE = 1
) (
  input logic                 clk,
  input logic                 rst,
  multicycle_control_if.master bus
);
  localparam logic [3:0] WAIT_N = 4'(MEM_WAIT);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11,
    BNEEX   = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  state_t     st, nxt;
  logic [3:0] cnt, nxt_cnt;
  logic       is_lw;
  logic       mem_hold;
  ctrl_t      ctrl_q;
  logic       illegal_q;

  // last_wait gates the FETCH side effects so the PC advances once per fetch.
  function automatic ctrl_t ctrl_of(input state_t s, input logic last_wait);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.ir_write  = last_wait;
        c.pc_write  = last_wait;
      end
      DECODE:  c.alu_src_b = 2'b11;
      MEMADR:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      MEMRD:   begin c.iord = 1'b1; c.mem_read = 1'b1; end
      MEMWB:   begin c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      MEMWR:   begin c.iord = 1'b1; c.mem_write = 1'b1; end
      RTYPEEX: begin c.alu_src_a = 1'b1; c.alu_op = 2'b10; end
      RTYPEWB: begin c.reg_dst = 1'b1; c.reg_write = 1'b1; end
      BEQEX: begin
        c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_source = 2'b01; c.branch = 1'b1;
      end
      BNEEX: begin
        c.alu_src_a = 1'b1; c.alu_op = 2'b01; c.pc_source = 2'b01; c.branch_ne = 1'b1;
      end
      ADDIEX:  begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; end
      ADDIWB:  c.reg_write = 1'b1;
      JEX:     begin c.pc_source = 2'b10; c.pc_write = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  assign mem_hold = ((st == FETCH) || (st == MEMRD) || (st == MEMWR)) && (cnt != WAIT_N);

  always_comb begin
    nxt     = FETCH;
    nxt_cnt = 4'd0;
    if (mem_hold) begin
      nxt     = st;
      nxt_cnt = cnt + 4'd1;
    end else begin
      case (st)
        FETCH:   nxt = DECODE;
        DECODE: begin
          case (bus.op)
            6'b000000:            nxt = RTYPEEX;
            6'b100011, 6'b101011: nxt = MEMADR;
            6'b000100:            nxt = BEQEX;
            6'b000101:            nxt = (ENABLE_BNE != 0) ? BNEEX : FETCH;
            6'b001000:            nxt = ADDIEX;
            6'b000010:            nxt = JEX;
            default:              nxt = FETCH;
          endcase
        end
        MEMADR:  nxt = is_lw ? MEMRD : MEMWR;
        MEMRD:   nxt = MEMWB;
        RTYPEEX: nxt = RTYPEWB;
        ADDIEX:  nxt = ADDIWB;
        default: nxt = FETCH;
      endcase
    end
  end

  // Outputs are registered from the next state so they line up with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st        <= FETCH;
      cnt       <= 4'd0;
      is_lw     <= 1'b0;
      ctrl_q    <= ctrl_of(FETCH, WAIT_N == 4'd0);
      illegal_q <= 1'b0;
    end else begin
      st        <= nxt;
      cnt       <= nxt_cnt;
      ctrl_q    <= ctrl_of(nxt, nxt_cnt == WAIT_N);
      illegal_q <= (st == DECODE) && (nxt == FETCH);
      if (st == DECODE) is_lw <= (bus.op == 6'b100011);
    end
  end

  assign bus.PCWrite    = ctrl_q.pc_write;
  assign bus.Branch     = ctrl_q.branch;
  assign bus.BranchNe   = ctrl_q.branch_ne;
  assign bus.IorD       = ctrl_q.iord;
  assign bus.MemRead    = ctrl_q.mem_read;
  assign bus.MemWrite   = ctrl_q.mem_write;
  assign bus.IRWrite    = ctrl_q.ir_write;
  assign bus.MemtoReg   = ctrl_q.mem_to_reg;
  assign bus.RegDst     = ctrl_q.reg_dst;
  assign bus.RegWrite   = ctrl_q.reg_write;
  assign bus.AluSrcA    = ctrl_q.alu_src_a;
  assign bus.AluSrcB    = ctrl_q.alu_src_b;
  assign bus.Alu_op     = ctrl_q.alu_op;
  assign bus.PCSource   = ctrl_q.pc_source;
  assign bus.state      = st;
  assign bus.illegal_op = illegal_q;
endmodule
